// File: rtl/dac_spi_tx.sv
// -----------------------------------------------------------------------------
// dac_spi_tx
//   Serialises 12-bit DDS samples into 16-bit SPI frames for a DAC.
//   Each frame is {CTRL_BITS, data_in}, sent MSB first. dac_din changes only
//   on the falling edge of dac_sclk, so the DAC samples it on the rising edge.
//   A frame holds dac_cs_n low for exactly 33*CLK_DIV cycles: 16 bits of
//   2*CLK_DIV cycles each, then CLK_DIV cycles of hold with dac_sclk low.
//
// Parameters
//   CLK_DIV    dac_sclk half-period in sys_clk cycles (1..255)
//   CTRL_BITS  control nibble sent as frame bits [15:12]
//   FRAME_GAP  extra dac_cs_n-high cycles after frame_done before ready (0..255)
//
// Ports
//   sys_clk     system clock, rising edge
//   rst_n       asynchronous active-low reset
//   data_in     12-bit unsigned sample
//   data_valid  sample qualifier; accepted when ready is high
//   ready       block accepts a sample this cycle
//   dac_cs_n    DAC chip select, active low
//   dac_sclk    serial clock, idles low
//   dac_din     serial data, MSB first
//   frame_done  one-cycle pulse as dac_cs_n returns high
//   overrun     one-cycle pulse after data_valid was seen while ready was low
// -----------------------------------------------------------------------------
module dac_spi_tx #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [3:0]  CTRL_BITS = 4'b0000,
  parameter int unsigned FRAME_GAP = 2
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [11:0] data_in,
  input  logic        data_valid,
  output logic        ready,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // Divider counts down the cycles left in the current sclk phase; it is
  // always reloaded explicitly and never relies on wrapping.
  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(FRAME_GAP);

  logic [1:0]  state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        ready_q, ready_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic        frame_done_q, frame_done_d;
  logic        overrun_q, overrun_d;

  logic accept;

  assign accept = data_valid && ready_q;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    ready_d      = ready_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    din_d        = din_q;
    frame_done_d = 1'b0;
    // Any sample offered while busy is dropped and flagged.
    overrun_d    = data_valid && !ready_q;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        din_d   = 1'b0;
        if (accept) begin
          // The whole word is captured here, so later data_in changes
          // cannot disturb the frame.
          shreg_d   = {CTRL_BITS, data_in};
          bit_cnt_d = 4'd15;
          div_cnt_d = DIV_RELOAD;
          ready_d   = 1'b0;
          cs_n_d    = 1'b0;
          din_d     = CTRL_BITS[3];
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (div_cnt_q != 8'd0) begin
          div_cnt_d = div_cnt_q - 8'd1;
        end else if (!sclk_q) begin
          // End of low phase: rising edge, DAC samples the current bit.
          sclk_d    = 1'b1;
          div_cnt_d = DIV_RELOAD;
        end else if (bit_cnt_q == 4'd0) begin
          // Last bit done: drop sclk and hold cs_n low; no 17th edge.
          sclk_d    = 1'b0;
          div_cnt_d = DIV_RELOAD;
          state_d   = S_HOLD;
        end else begin
          // Falling edge: the only place dac_din moves to the next bit.
          sclk_d    = 1'b0;
          shreg_d   = {shreg_q[14:0], 1'b0};
          din_d     = shreg_q[14];
          bit_cnt_d = bit_cnt_q - 4'd1;
          div_cnt_d = DIV_RELOAD;
        end
      end

      S_HOLD: begin
        if (div_cnt_q != 8'd0) begin
          div_cnt_d = div_cnt_q - 8'd1;
        end else begin
          cs_n_d       = 1'b1;
          din_d        = 1'b0;
          frame_done_d = 1'b1;
          gap_cnt_d    = GAP_LOAD;
          state_d      = S_GAP;
        end
      end

      S_GAP: begin
        // The first GAP cycle is the frame_done cycle; FRAME_GAP more
        // cycles follow before ready returns.
        if (gap_cnt_q != 8'd0) begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end else begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        ready_d = 1'b1;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        din_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      // Async reset raises cs_n immediately, aborting any frame in flight.
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      ready_q      <= 1'b1;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      din_q        <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every register see the values from
      // before this edge, matching real flip-flop behaviour.
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      ready_q      <= ready_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      din_q        <= din_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ready      = ready_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_sclk   = sclk_q;
  assign dac_din    = din_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_tx
//   Three dac_spi_tx instances with different parameter sets:
//     0: CLK_DIV=2, CTRL_BITS=0000, FRAME_GAP=2
//     1: CLK_DIV=1, CTRL_BITS=0000, FRAME_GAP=0
//     2: CLK_DIV=2, CTRL_BITS=1011, FRAME_GAP=2
//   Every accepted sample pushes {CTRL, data_in} into a per-instance queue;
//   a bus monitor rebuilds each frame from rising sclk edges and compares it
//   with the queue head, along with frame timing and handshake behaviour.
// -----------------------------------------------------------------------------
module tb_dac_spi_tx;

  localparam int N = 3;
  localparam int DIV [N] = '{2, 1, 2};
  localparam int GAP [N] = '{2, 0, 2};
  localparam logic [3:0] CTRL [N] = '{4'b0000, 4'b0000, 4'b1011};

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [11:0] data_in    [N];
  logic        data_valid [N];
  logic        ready      [N];
  logic        cs_n       [N];
  logic        sclk       [N];
  logic        din        [N];
  logic        fd         [N];
  logic        ovr        [N];

  always #5 sys_clk = ~sys_clk;

  dac_spi_tx #(.CLK_DIV(2), .CTRL_BITS(4'b0000), .FRAME_GAP(2)) u_dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .data_in(data_in[0]), .data_valid(data_valid[0]),
    .ready(ready[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_din(din[0]),
    .frame_done(fd[0]), .overrun(ovr[0]));

  dac_spi_tx #(.CLK_DIV(1), .CTRL_BITS(4'b0000), .FRAME_GAP(0)) u_dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .data_in(data_in[1]), .data_valid(data_valid[1]),
    .ready(ready[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_din(din[1]),
    .frame_done(fd[1]), .overrun(ovr[1]));

  dac_spi_tx #(.CLK_DIV(2), .CTRL_BITS(4'b1011), .FRAME_GAP(2)) u_dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .data_in(data_in[2]), .data_valid(data_valid[2]),
    .ready(ready[2]), .dac_cs_n(cs_n[2]), .dac_sclk(sclk[2]), .dac_din(din[2]),
    .frame_done(fd[2]), .overrun(ovr[2]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard and monitor state
  logic [15:0] sb_q [N][$];
  logic        prev_cs   [N];
  logic        prev_sclk [N];
  logic        prev_din  [N];
  logic [15:0] cap       [N];
  int          bits      [N];
  int          low_cnt   [N];
  int          viol      [N];
  int          wait_cnt  [N];
  logic        waiting   [N];
  logic        exp_ovr   [N];
  logic        ovr_arm   [N];
  int          last_word [N];
  bit          incr_mode = 1'b0;
  int          idle_viol = 0;

  // Accept detector: runs in the active region of the edge, so it sees the
  // pre-edge ready value, exactly what the DUT uses for its handshake.
  initial begin
    forever begin
      @(posedge sys_clk);
      for (int i = 0; i < N; i++) begin
        if (rst_n && data_valid[i] && ready[i])
          sb_q[i].push_back({CTRL[i], data_in[i]});
      end
    end
  end

  // Bus monitor, sampling on the falling sys_clk edge.
  initial begin
    logic        frame_end;
    logic [15:0] exp_w;
    forever begin
      @(negedge sys_clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          sb_q[i].delete();
          prev_cs[i]   = 1'b1;
          prev_sclk[i] = 1'b0;
          prev_din[i]  = 1'b0;
          waiting[i]   = 1'b0;
          ovr_arm[i]   = 1'b0;
          bits[i]      = 0;
          low_cnt[i]   = 0;
        end else begin
          if (cs_n[i] && sclk[i]) idle_viol++;

          if (ovr_arm[i]) check($sformatf("overrun%0d", i), ovr[i], exp_ovr[i]);
          exp_ovr[i] = data_valid[i] && !ready[i];
          ovr_arm[i] = 1'b1;

          if (waiting[i]) begin
            wait_cnt[i]++;
            if (wait_cnt[i] == 1) check($sformatf("fd_single%0d", i), fd[i], 0);
            if (ready[i]) begin
              check($sformatf("ready_after_fd%0d", i), wait_cnt[i], GAP[i] + 1);
              waiting[i] = 1'b0;
            end
          end

          if (!cs_n[i]) begin
            if (prev_cs[i]) begin
              cap[i]     = '0;
              bits[i]    = 0;
              low_cnt[i] = 1;
              viol[i]    = 0;
            end else begin
              low_cnt[i]++;
              if (din[i] != prev_din[i] && !(prev_sclk[i] && !sclk[i])) viol[i]++;
            end
            if (!prev_sclk[i] && sclk[i]) begin
              cap[i] = {cap[i][14:0], din[i]};
              bits[i]++;
            end
          end

          frame_end = !prev_cs[i] && cs_n[i];
          if (fd[i] && !frame_end) check($sformatf("fd_spurious%0d", i), fd[i], 0);

          if (frame_end) begin
            if (sb_q[i].size() == 0) begin
              check($sformatf("sb_nonempty%0d", i), 0, 1);
            end else begin
              exp_w = sb_q[i].pop_front();
              check($sformatf("word%0d", i), cap[i], exp_w);
            end
            check($sformatf("rise_edges%0d", i), bits[i], 16);
            check($sformatf("cs_low_cycles%0d", i), low_cnt[i], 33 * DIV[i]);
            check($sformatf("din_stable%0d", i), viol[i], 0);
            check($sformatf("fd_at_end%0d", i), fd[i], 1);
            if (incr_mode && i < 2) begin
              check($sformatf("incr%0d", i), 32'(int'(cap[i]) > last_word[i]), 1);
              last_word[i] = int'(cap[i]);
            end
            waiting[i]  = 1'b1;
            wait_cnt[i] = 0;
          end

          prev_cs[i]   = cs_n[i];
          prev_sclk[i] = sclk[i];
          prev_din[i]  = din[i];
        end
      end
    end
  end

  function automatic bit all_idle();
    for (int i = 0; i < N; i++) begin
      if (sb_q[i].size() != 0 || !ready[i] || waiting[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_all_idle(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge sys_clk);
      #1;
      done = all_idle();
      n++;
    end
    if (!done) check("idle_timeout", 1, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      data_in[i]    = '0;
      data_valid[i] = 1'b0;
      last_word[i]  = -1;
    end

    // Reset state
    repeat (2) @(negedge sys_clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_ready%0d", i), ready[i], 1);
      check($sformatf("rst_cs_n%0d", i), cs_n[i], 1);
      check($sformatf("rst_sclk%0d", i), sclk[i], 0);
      check($sformatf("rst_din%0d", i), din[i], 0);
      check($sformatf("rst_fd%0d", i), fd[i], 0);
      check($sformatf("rst_ovr%0d", i), ovr[i], 0);
    end
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);

    // Single frames: A5C, FFF at CLK_DIV=1, 800 with control nibble 1011
    #1;
    data_in[0] = 12'hA5C;
    data_in[1] = 12'hFFF;
    data_in[2] = 12'h800;
    for (int i = 0; i < N; i++) data_valid[i] = 1'b1;
    @(posedge sys_clk); #1;
    for (int i = 0; i < N; i++) data_valid[i] = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    data_in[2] = 12'h7FF;
    data_in[0] = 12'h000;
    wait_all_idle(400);

    // Continuous valid with stepping data on instances 0 and 1
    @(posedge sys_clk); #1;
    incr_mode     = 1'b1;
    data_in[0]    = 12'h000;
    data_in[1]    = 12'h000;
    data_valid[0] = 1'b1;
    data_valid[1] = 1'b1;
    repeat (400) begin
      @(posedge sys_clk); #1;
      data_in[0] = data_in[0] + 12'd1;
      data_in[1] = data_in[1] + 12'd1;
    end
    data_valid[0] = 1'b0;
    data_valid[1] = 1'b0;
    wait_all_idle(400);
    incr_mode = 1'b0;

    // Reset part-way through a 123 frame, then a clean 456 frame
    @(posedge sys_clk); #1;
    data_in[0]    = 12'h123;
    data_valid[0] = 1'b1;
    @(posedge sys_clk); #1;
    data_valid[0] = 1'b0;
    n = 0;
    while (bits[0] < 9 && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    if (bits[0] < 9) check("bit7_timeout", 1, 0);
    @(posedge sys_clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", cs_n[0], 1);
    check("abort_sclk", sclk[0], 0);
    check("abort_fd", fd[0], 0);
    check("abort_din", din[0], 0);
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    data_in[0]    = 12'h456;
    data_valid[0] = 1'b1;
    @(posedge sys_clk); #1;
    data_valid[0] = 1'b0;
    wait_all_idle(400);

    check("sclk_low_while_cs_high", idle_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
